// File: rtl/misr_pkg.sv
// Shared MISR types, default constants and the signature update function.
package misr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } misr_state_t;

    localparam int           MISR_MAX_W    = 64;
    localparam logic [2:0]   MISR_DEF_POLY = 3'b011;
    localparam logic [2:0]   MISR_DEF_SEED = 3'b000;

    // Callers zero-extend into MISR_MAX_W and keep the low width bits of the result.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] m,
        input logic [MISR_MAX_W-1:0] poly,
        input int                    width
    );
        logic fb;
        fb = sig[width-1];
        return (sig << 1) ^ m ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/misr_window_cnt.sv
// Saturating count of accepted samples; last flags the sample that completes the window.
module misr_window_cnt #(
    parameter int NUM_PATTERNS = 8,
    parameter int CW           = $clog2(NUM_PATTERNS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = inc && (cnt == CW'(NUM_PATTERNS - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt < CW'(NUM_PATTERNS))) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/misr_compactor.sv
// Windowed MISR compacting NUM_PATTERNS valid responses into a registered signature.
// Optional golden compare under `define MISR_GOLDEN_CMP_EN; otherwise pass is tied low.
module misr_compactor
    import misr_pkg::*;
#(
    parameter int               WIDTH        = 3,
    parameter logic [WIDTH-1:0] POLY         = WIDTH'(MISR_DEF_POLY),
    parameter logic [WIDTH-1:0] SEED         = WIDTH'(MISR_DEF_SEED),
    parameter int               NUM_PATTERNS = 8,
    parameter logic [WIDTH-1:0] GOLDEN       = '0,
    parameter int               CW           = $clog2(NUM_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             m_valid,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    sample_cnt
);

    misr_state_t      state;
    logic [WIDTH-1:0] nxt;
    logic             accept;
    logic             last;
    logic             reload;

    assign nxt    = WIDTH'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(m),
                                     MISR_MAX_W'(POLY), WIDTH));
    assign accept = (state == RUN) && m_valid;
    assign reload = (state != RUN) && start;

    misr_window_cnt #(
        .NUM_PATTERNS (NUM_PATTERNS),
        .CW           (CW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (reload),
        .inc   (accept),
        .cnt   (sample_cnt),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sig   <= SEED;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        sig   <= SEED;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (m_valid) begin
                        sig <= nxt;
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MISR_GOLDEN_CMP_EN
    // Judged on next_sig so the verdict lands on the same edge as done.
    always_ff @(posedge clk) begin
        if (!reset || reload) begin
            pass <= 1'b0;
        end else if (accept && last) begin
            pass <= (nxt == GOLDEN);
        end
    end
`else
    assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_misr_compactor.sv
// Directed scoreboard bench: 3-bit/4-sample window plus an 8-bit single-sample window.
module tb_misr_compactor;

`ifdef MISR_GOLDEN_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       a_start, a_valid;
    logic [2:0] a_m;
    logic [2:0] a_sig;
    logic       a_busy, a_done, a_pass;
    logic [2:0] a_cnt;
    logic       b_start, b_valid;
    logic [7:0] b_m;
    logic [7:0] b_sig;
    logic       b_busy, b_done, b_pass;
    logic [0:0] b_cnt;

    always #5 clk = ~clk;

    misr_compactor #(
        .WIDTH(3), .POLY(3'b011), .SEED(3'b000), .NUM_PATTERNS(4), .GOLDEN(3'b011)
    ) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .m_valid(a_valid), .m(a_m),
        .sig(a_sig), .busy(a_busy), .done(a_done), .pass(a_pass), .sample_cnt(a_cnt)
    );

    misr_compactor #(
        .WIDTH(8), .POLY(8'h1D), .SEED(8'hFF), .NUM_PATTERNS(1), .GOLDEN(8'hFF)
    ) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .m_valid(b_valid), .m(b_m),
        .sig(b_sig), .busy(b_busy), .done(b_done), .pass(b_pass), .sample_cnt(b_cnt)
    );

    typedef struct {
        bit         inst;
        logic [7:0] sig;
        logic       busy;
        logic       done;
        logic       pass;
        int         cnt;
        int         id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    task automatic chk(input string name, input int id, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    // Monitor: compares the post-edge DUT state against whatever the stimulus queued.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            if (!e.inst) begin
                chk("a_sig",  e.id, int'(a_sig),  int'(e.sig));
                chk("a_busy", e.id, int'(a_busy), int'(e.busy));
                chk("a_done", e.id, int'(a_done), int'(e.done));
                chk("a_pass", e.id, int'(a_pass), int'(e.pass));
                chk("a_cnt",  e.id, int'(a_cnt),  e.cnt);
            end else begin
                chk("b_sig",  e.id, int'(b_sig),  int'(e.sig));
                chk("b_busy", e.id, int'(b_busy), int'(e.busy));
                chk("b_done", e.id, int'(b_done), int'(e.done));
                chk("b_pass", e.id, int'(b_pass), int'(e.pass));
                chk("b_cnt",  e.id, int'(b_cnt),  e.cnt);
            end
        end
    end

    task automatic push(input bit inst, input logic [7:0] s, input logic bz,
                        input logic dn, input logic ps, input int c);
        exp_t e;
        e.inst = inst; e.sig = s; e.busy = bz; e.done = dn;
        e.pass = ps & CMP_EN; e.cnt = c; e.id = step_id;
        q.push_back(e);
        step_id++;
    endtask

    task automatic step_a(input logic r, input logic st, input logic v, input logic [2:0] mm,
                          input logic [2:0] es, input logic eb, input logic ed,
                          input logic ep, input int ec);
        @(negedge clk);
        reset = r; a_start = st; a_valid = v; a_m = mm;
        @(posedge clk);
        push(1'b0, {5'b0, es}, eb, ed, ep, ec);
    endtask

    task automatic step_b(input logic st, input logic v, input logic [7:0] mm,
                          input logic [7:0] es, input logic eb, input logic ed, input int ec);
        @(negedge clk);
        reset = 1'b1; b_start = st; b_valid = v; b_m = mm;
        @(posedge clk);
        push(1'b1, es, eb, ed, 1'b0, ec);
    endtask

    initial begin
        reset = 1'b0;
        a_start = 1'b0; a_valid = 1'b0; a_m = '0;
        b_start = 1'b0; b_valid = 1'b0; b_m = '0;

        // Reset and idle: seed value, nothing running, IDLE ignores m.
        step_a(0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        step_a(1, 0, 1, 3'b101, 3'b000, 0, 0, 0, 0);

        // Back-to-back window: 001,000,000,000 -> 001,010,100,011.
        step_a(1, 1, 0, 3'b000, 3'b000, 1, 0, 0, 0);
        step_a(1, 0, 1, 3'b001, 3'b001, 1, 0, 0, 1);
        step_a(1, 0, 1, 3'b000, 3'b010, 1, 0, 0, 2);
        step_a(1, 0, 1, 3'b000, 3'b100, 1, 0, 0, 3);
        step_a(1, 0, 1, 3'b000, 3'b011, 0, 1, 1, 4);
        // DONE is frozen and m is ignored.
        step_a(1, 0, 1, 3'b111, 3'b011, 0, 1, 1, 4);

        // start+m_valid in DONE: only the seed loads.
        step_a(1, 1, 1, 3'b111, 3'b000, 1, 0, 0, 0);
        // Same stream with 2-cycle gaps; start in RUN is ignored.
        step_a(1, 0, 1, 3'b001, 3'b001, 1, 0, 0, 1);
        step_a(1, 0, 0, 3'b111, 3'b001, 1, 0, 0, 1);
        step_a(1, 1, 0, 3'b111, 3'b001, 1, 0, 0, 1);
        step_a(1, 0, 1, 3'b000, 3'b010, 1, 0, 0, 2);
        step_a(1, 0, 0, 3'b110, 3'b010, 1, 0, 0, 2);
        step_a(1, 0, 0, 3'b110, 3'b010, 1, 0, 0, 2);
        step_a(1, 1, 1, 3'b000, 3'b100, 1, 0, 0, 3);
        step_a(1, 0, 0, 3'b011, 3'b100, 1, 0, 0, 3);
        step_a(1, 0, 0, 3'b011, 3'b100, 1, 0, 0, 3);
        step_a(1, 0, 1, 3'b000, 3'b011, 0, 1, 1, 4);

        // Reset mid-window wins over start and m_valid.
        step_a(1, 1, 0, 3'b000, 3'b000, 1, 0, 0, 0);
        step_a(1, 0, 1, 3'b001, 3'b001, 1, 0, 0, 1);
        step_a(1, 0, 1, 3'b000, 3'b010, 1, 0, 0, 2);
        step_a(0, 1, 1, 3'b111, 3'b000, 0, 0, 0, 0);
        step_a(1, 0, 1, 3'b101, 3'b000, 0, 0, 0, 0);
        step_a(1, 1, 0, 3'b000, 3'b000, 1, 0, 0, 0);
        step_a(1, 0, 1, 3'b001, 3'b001, 1, 0, 0, 1);
        step_a(1, 0, 1, 3'b000, 3'b010, 1, 0, 0, 2);
        step_a(1, 0, 1, 3'b000, 3'b100, 1, 0, 0, 3);
        step_a(1, 0, 1, 3'b000, 3'b011, 0, 1, 1, 4);
        step_a(1, 0, 0, 3'b000, 3'b011, 0, 1, 1, 4);

        // 8-bit, POLY 1D, seed FF, one-sample window; GOLDEN FF never matches.
        // FF, m=00: shifted FE, feedback 1 -> FE ^ 1D = E3.
        step_b(0, 1, 8'h55, 8'hFF, 0, 0, 0);
        step_b(1, 0, 8'h00, 8'hFF, 1, 0, 0);
        step_b(0, 1, 8'h00, 8'hE3, 0, 1, 1);
        step_b(0, 1, 8'h7F, 8'hE3, 0, 1, 1);
        // Rerun with m=01 -> E3 ^ 01 = E2.
        step_b(1, 0, 8'h00, 8'hFF, 1, 0, 0);
        step_b(0, 0, 8'h00, 8'hFF, 1, 0, 0);
        step_b(0, 1, 8'h01, 8'hE2, 0, 1, 1);

        @(negedge clk);
        b_start = 1'b0; b_valid = 1'b0;
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
